// File: rtl/reg_bank16.sv
`default_nettype none
// ============================================================================
// reg_bank16 : 16 x 32-bit register bank, two byte-enabled write ports,
//              dirty bitmap and write acks. Option macro: R0_ZERO_EN.
// Rev 1.0
// ============================================================================
module reg_bank16 #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_a,
  input  logic [3:0]       waddr_a,
  input  logic [WIDTH-1:0] wdata_a,
  input  logic [3:0]       wbe_a,
  input  logic             we_b,
  input  logic [3:0]       waddr_b,
  input  logic [WIDTH-1:0] wdata_b,
  input  logic [3:0]       wbe_b,
  input  logic             clr_dirty,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [WIDTH-1:0] q4,
  output logic [WIDTH-1:0] q5,
  output logic [WIDTH-1:0] q6,
  output logic [WIDTH-1:0] q7,
  output logic [WIDTH-1:0] q8,
  output logic [WIDTH-1:0] q9,
  output logic [WIDTH-1:0] q10,
  output logic [WIDTH-1:0] q11,
  output logic [WIDTH-1:0] q12,
  output logic [WIDTH-1:0] q13,
  output logic [WIDTH-1:0] q14,
  output logic [WIDTH-1:0] q15,
  output logic [15:0]      dirty,
  output logic             wr_ack_a,
  output logic             wr_ack_b,
  output logic             collide
);
  localparam int unsigned NREG  = 16;
  localparam int unsigned NBYTE = 4;

  logic [WIDTH-1:0] r_regs [NREG];
  logic [WIDTH-1:0] w_next [NREG];
  logic [NREG-1:0]  r_dirty;
  logic [NREG-1:0]  w_dirty_nxt;
  logic [NREG-1:0]  w_hit_a;
  logic [NREG-1:0]  w_hit_b;
  logic             w_eff_a;
  logic             w_eff_b;
  logic             w_collide;
  logic             r_ack_a;
  logic             r_ack_b;
  logic             r_collide;

  assign w_eff_a   = we_a & (|wbe_a);
  assign w_eff_b   = we_b & (|wbe_b);
  assign w_collide = w_eff_a & w_eff_b & (waddr_a == waddr_b);

  always_comb begin
    for (int n = 0; n < NREG; n++) begin
      w_hit_a[n] = w_eff_a && (waddr_a == 4'(n));
      w_hit_b[n] = w_eff_b && (waddr_b == 4'(n));
    end
  end

  // Port A owns every byte it enables; port B only fills bytes A leaves alone.
  always_comb begin
    for (int n = 0; n < NREG; n++) begin
      w_next[n] = r_regs[n];
      for (int i = 0; i < NBYTE; i++) begin
        if (w_hit_a[n] && wbe_a[i])
          w_next[n][8*i +: 8] = wdata_a[8*i +: 8];
        else if (w_hit_b[n] && wbe_b[i])
          w_next[n][8*i +: 8] = wdata_b[8*i +: 8];
      end
    end
    w_dirty_nxt = (clr_dirty ? '0 : r_dirty) | w_hit_a | w_hit_b;
`ifdef R0_ZERO_EN
    w_next[0]      = '0;
    w_dirty_nxt[0] = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NREG; n++) r_regs[n] <= RESET_VAL;
      r_dirty   <= '0;
      r_ack_a   <= 1'b0;
      r_ack_b   <= 1'b0;
      r_collide <= 1'b0;
    end else begin
      for (int n = 0; n < NREG; n++) r_regs[n] <= w_next[n];
      r_dirty   <= w_dirty_nxt;
      r_ack_a   <= w_eff_a;
      r_ack_b   <= w_eff_b;
      r_collide <= w_collide;
    end
  end

`ifdef R0_ZERO_EN
  assign q0 = '0;
`else
  assign q0 = r_regs[0];
`endif
  assign q1  = r_regs[1];
  assign q2  = r_regs[2];
  assign q3  = r_regs[3];
  assign q4  = r_regs[4];
  assign q5  = r_regs[5];
  assign q6  = r_regs[6];
  assign q7  = r_regs[7];
  assign q8  = r_regs[8];
  assign q9  = r_regs[9];
  assign q10 = r_regs[10];
  assign q11 = r_regs[11];
  assign q12 = r_regs[12];
  assign q13 = r_regs[13];
  assign q14 = r_regs[14];
  assign q15 = r_regs[15];

  assign dirty    = r_dirty;
  assign wr_ack_a = r_ack_a;
  assign wr_ack_b = r_ack_b;
  assign collide  = r_collide;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank16.sv
`default_nettype none
// ============================================================================
// tb_reg_bank16 : directed vectors with a stamped scoreboard for reg_bank16.
// Rev 1.0
// ============================================================================
module tb_reg_bank16;
  localparam logic [31:0] RV = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we_a = 1'b0, we_b = 1'b0, clr_dirty = 1'b0;
  logic [3:0]  waddr_a = '0, waddr_b = '0, wbe_a = '0, wbe_b = '0;
  logic [31:0] wdata_a = '0, wdata_b = '0;
  logic [31:0] q [0:15];
  logic [15:0] dirty;
  logic        wr_ack_a, wr_ack_b, collide;

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          stamp;
    int          idx;
    logic        all;
    logic [31:0] eq;
    logic [15:0] ed;
    logic        ea;
    logic        eb;
    logic        ec;
  } exp_t;

  exp_t sb [$];

  reg_bank16 #(.WIDTH(32), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst),
    .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a), .wbe_a(wbe_a),
    .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b), .wbe_b(wbe_b),
    .clr_dirty(clr_dirty),
    .q0(q[0]), .q1(q[1]), .q2(q[2]), .q3(q[3]),
    .q4(q[4]), .q5(q[5]), .q6(q[6]), .q7(q[7]),
    .q8(q[8]), .q9(q[9]), .q10(q[10]), .q11(q[11]),
    .q12(q[12]), .q13(q[13]), .q14(q[14]), .q15(q[15]),
    .dirty(dirty), .wr_ack_a(wr_ack_a), .wr_ack_b(wr_ack_b), .collide(collide)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int stamp, input int idx, input logic all, input logic [31:0] eq,
                      input logic [15:0] ed, input logic ea, input logic eb, input logic ec);
    exp_t e;
    e.stamp = stamp; e.idx = idx; e.all = all; e.eq = eq;
    e.ed = ed; e.ea = ea; e.eb = eb; e.ec = ec;
    sb.push_back(e);
  endtask

  // One cycle of stimulus; result is checked after the next rising edge.
  task automatic drive(input logic wa, input logic [3:0] aa, input logic [31:0] da, input logic [3:0] ba,
                       input logic wb, input logic [3:0] ab, input logic [31:0] db, input logic [3:0] bb,
                       input logic clr, input int idx, input logic all, input logic [31:0] eq,
                       input logic [15:0] ed, input logic ea, input logic eb, input logic ec);
    @(posedge clk); #1;
    we_a = wa; waddr_a = aa; wdata_a = da; wbe_a = ba;
    we_b = wb; waddr_b = ab; wdata_b = db; wbe_b = bb;
    clr_dirty = clr;
    push(cyc + 1, idx, all, eq, ed, ea, eb, ec);
  endtask

  task automatic idle(input int idx, input logic all, input logic [31:0] eq, input logic [15:0] ed);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, idx, all, eq, ed, 0, 0, 0);
  endtask

  // Monitor: compares whatever the DUT presents against the record stamped for this cycle.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].stamp == cyc) begin
      exp_t e;
      logic [31:0] ev;
      e = sb.pop_front();
      if (e.all) begin
        for (int n = 0; n < 16; n++) begin
          ev = e.eq;
`ifdef R0_ZERO_EN
          if (n == 0) ev = 32'h0;
`endif
          chk($sformatf("q%0d", n), q[n], ev);
        end
      end else begin
        chk($sformatf("q%0d", e.idx), q[e.idx], e.eq);
      end
      chk("dirty", {16'h0, dirty}, {16'h0, e.ed});
      chk("wr_ack_a", {31'h0, wr_ack_a}, {31'h0, e.ea});
      chk("wr_ack_b", {31'h0, wr_ack_b}, {31'h0, e.eb});
      chk("collide", {31'h0, collide}, {31'h0, e.ec});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    idle(0, 1, RV, 16'h0000);
    drive(1, 4'd3, 32'h1122_3344, 4'hF, 0, 0, 0, 0, 0, 3, 0, 32'h1122_3344, 16'h0008, 1, 0, 0);
    drive(1, 4'd3, 32'hAABB_CCDD, 4'b0101, 0, 0, 0, 0, 0, 3, 0, 32'h11BB_33DD, 16'h0008, 1, 0, 0);
    idle(3, 0, 32'h11BB_33DD, 16'h0008);
    drive(1, 4'd5, 32'h5, 4'hF, 1, 4'd9, 32'h9, 4'hF, 0, 5, 0, 32'h5, 16'h0228, 1, 1, 0);
    idle(9, 0, 32'h9, 16'h0228);
    drive(0, 0, 0, 0, 1, 4'd7, 32'h0, 4'hF, 0, 7, 0, 32'h0, 16'h02A8, 0, 1, 0);
    drive(1, 4'd7, 32'hAAAA_AAAA, 4'b0011, 1, 4'd7, 32'hBBBB_BBBB, 4'b1111, 0,
          7, 0, 32'hBBBB_AAAA, 16'h02A8, 1, 1, 1);
    idle(7, 0, 32'hBBBB_AAAA, 16'h02A8);
    drive(1, 4'd2, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2, 0, RV, 16'h02A8, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 32'h11BB_33DD, 16'h0000, 0, 0, 0);
`ifdef R0_ZERO_EN
    drive(1, 4'd0, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 0, 0, 0, 0, 32'h0, 16'h0000, 1, 0, 0);
`else
    drive(1, 4'd0, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 16'h0001, 1, 0, 0);
`endif
    drive(1, 4'd4, 32'h44, 4'hF, 0, 0, 0, 0, 1, 4, 0, 32'h44, 16'h0010, 1, 0, 0);
    drive(1, 4'd4, 32'h100, 4'hF, 0, 0, 0, 0, 0, 4, 0, 32'h100, 16'h0010, 1, 0, 0);
    drive(1, 4'd4, 32'h200, 4'hF, 0, 0, 0, 0, 0, 4, 0, 32'h200, 16'h0010, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 4'd15, 32'hCAFE_F00D, 4'b1000, 0, 15, 0, 32'hCAAD_BEEF, 16'h8010, 0, 1, 0);
    idle(15, 0, 32'hCAAD_BEEF, 16'h8010);

    // Asynchronous reset mid-cycle, with a write held on the port throughout.
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    we_a = 1'b1; waddr_a = 4'd3; wdata_a = 32'h1234_5678; wbe_a = 4'hF;
    push(cyc, 0, 1, RV, 16'h0000, 0, 0, 0);
    @(posedge clk); #1;
    push(cyc, 0, 1, RV, 16'h0000, 0, 0, 0);
    rst = 1'b0;
    we_a = 1'b0;
    idle(0, 1, RV, 16'h0000);

    repeat (3) @(posedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
